result_writer: RTL

- Write-side counterpart of test_controller's SRAM stimulus reader.
- Drains 30-bit DUT result words from the result FIFO. The FIFO is filled by dut_if.
- Stores each result into SRAM as two 16-bit writes through the same sopc-style master port that the SRAM arbiter exposes.
- On request, appends an end-of-results marker so host software can find the end of the result region.

---
 rtl/chip_tester_pkg.sv | 25 ++
 rtl/result_writer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/chip_tester_pkg.sv
// Shared types and defaults for the chip tester: writer FSM states,
// result-region layout and the result word type.
package chip_tester_pkg;

    // Result writer FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_LO   = 3'd1,
        WR_HI   = 3'd2,
        DISCARD = 3'd3,
        MK_LO   = 3'd4,
        MK_HI   = 3'd5
    } wr_state_e;

    // Default result region: upper half of a 1M-word SRAM.
    localparam logic [19:0] RW_BASE_ADDR  = 20'h80000;
    localparam logic [19:0] RW_LIMIT_ADDR = 20'hFFFFF;
    // End-of-results terminator, written as two consecutive words.
    localparam logic [15:0] RW_MARKER     = 16'hFFFF;

    // One DUT result as carried by the result FIFO.
    localparam int RESULT_W = 30;
    typedef logic [RESULT_W-1:0] result_word_t;

endpackage

// File: rtl/result_writer.sv
// Drains result words from a show-ahead FIFO and stores each one in SRAM as
// a low/high pair of data words through an sopc-style master port. On a
// finish request an end-of-results marker pair is appended once the FIFO is
// empty.
//
// Bus handshake: while write=1 the address, writedata and byteenable are held
// stable; a transfer completes on the rising edge where write=1 and
// waitrequest=0, and each write state issues exactly one transfer.
module result_writer
    import chip_tester_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 20,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    RESULT_WIDTH = 30,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = RW_BASE_ADDR,
    parameter logic [ADDR_WIDTH-1:0] LIMIT_ADDR   = RW_LIMIT_ADDR,
    parameter logic [DATA_WIDTH-1:0] MARKER       = RW_MARKER
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    enable,
    input  logic                    finish,
    input  logic [RESULT_WIDTH-1:0] rfifo_dataq,
    input  logic                    rfifo_rdempty,
    output logic                    rfifo_rdreq,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [1:0]              byteenable,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    waitrequest,
    output logic                    done,
    output logic                    overflow,
    output logic [ADDR_WIDTH-1:0]   result_count
);

    wr_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d;
    logic [RESULT_WIDTH-1:0]   hold_q, hold_d;
    logic [ADDR_WIDTH-1:0]     count_q, count_d;
    logic                      done_q, done_d;
    logic                      ovf_q, ovf_d;
    logic                      fin_pend_q, fin_pend_d;

    logic                      start_idle;
    logic                      pop_ok;
    logic                      room;
    logic [ADDR_WIDTH-1:0]     ptr_inc;
    logic [2*DATA_WIDTH-1:0]   hold_ext;

    // start only acts in IDLE and takes precedence over a pop in that cycle.
    assign start_idle = start && (state_q == IDLE);
    assign pop_ok     = (state_q == IDLE) && enable && !rfifo_rdempty && !done_q && !start;
    // Two more words fit only while the pointer is at or below LIMIT_ADDR-1.
    assign room       = (ptr_q < LIMIT_ADDR);
    // The pointer saturates at LIMIT_ADDR instead of wrapping.
    assign ptr_inc    = (ptr_q == LIMIT_ADDR) ? ptr_q : ptr_q + ADDR_WIDTH'(1);

    // Next-state logic, FIFO pop, pointer/status updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        count_d     = count_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        fin_pend_d  = fin_pend_q;
        rfifo_rdreq = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_idle) begin
                    ptr_d      = BASE_ADDR;
                    count_d    = '0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                    fin_pend_d = 1'b0;
                end else if (pop_ok) begin
                    rfifo_rdreq = 1'b1;
                    hold_d      = rfifo_dataq;
                    if (ovf_q || !room) begin
                        ovf_d   = 1'b1;
                        state_d = DISCARD;
                    end else begin
                        state_d = WR_LO;
                    end
                end else if (fin_pend_q && rfifo_rdempty) begin
                    if (!ovf_q && room) begin
                        state_d = MK_LO;
                    end else begin
                        // No space for the marker: terminate without it.
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            WR_LO: begin
                if (!waitrequest) begin
                    ptr_d   = ptr_inc;
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                if (!waitrequest) begin
                    ptr_d   = ptr_inc;
                    count_d = count_q + ADDR_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                state_d = IDLE;
            end
            MK_LO: begin
                if (!waitrequest) begin
                    ptr_d   = ptr_inc;
                    state_d = MK_HI;
                end
            end
            MK_HI: begin
                if (!waitrequest) begin
                    ptr_d   = ptr_inc;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // finish is ignored once done, unless start re-arms in the same cycle.
        if (finish && (!done_q || start_idle)) begin
            fin_pend_d = 1'b1;
        end
        if (done_d) begin
            fin_pend_d = 1'b0;
        end
    end

    // Bus outputs decoded from state; hold_q and ptr_q keep them stable during stalls.
    always_comb begin
        hold_ext                   = '0;
        hold_ext[RESULT_WIDTH-1:0] = hold_q;
        write                      = 1'b0;
        writedata                  = '0;
        case (state_q)
            WR_LO: begin
                write     = 1'b1;
                writedata = hold_ext[DATA_WIDTH-1:0];
            end
            WR_HI: begin
                write     = 1'b1;
                writedata = hold_ext[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            MK_LO, MK_HI: begin
                write     = 1'b1;
                writedata = MARKER;
            end
            default: begin
                write     = 1'b0;
                writedata = '0;
            end
        endcase
        byteenable = write ? 2'b11 : 2'b00;
    end

    assign address      = ptr_q;
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign result_count = count_q;

    // State register; reset drops any in-flight write immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= BASE_ADDR;
            hold_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            fin_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            fin_pend_q <= fin_pend_d;
        end
    end

endmodule
